// File: rtl/golden_nonce_queue.sv
// golden_nonce_queue: offset-corrected golden-nonce FIFO with valid/ready drain, drop counting and flush.
// Optional GOLDEN_NONCE_DEDUP_EN discards pushes repeating the last accepted corrected nonce.
module golden_nonce_queue #(
    parameter int          DEPTH        = 8,
    parameter logic [31:0] NONCE_OFFSET = 32'd0
) (
    input  logic                       hash_clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [31:0]                in_nonce,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [31:0]                out_nonce,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic [15:0]                drop_count,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [15:0]   r_drop;
    logic          r_ovf;

    logic [31:0]   w_corr;
    logic          w_full;
    logic          w_pop;
    logic          w_req;
    logic          w_push;
    logic          w_drop;
    logic [CW-1:0] w_count_nxt;

    assign w_corr = in_nonce - NONCE_OFFSET;
    assign w_full = r_count == CW'(DEPTH);
    assign w_pop  = (r_count != '0) && out_ready && !flush;

`ifdef GOLDEN_NONCE_DEDUP_EN
    logic [31:0] r_last;
    logic        r_last_v;
    logic        w_dup;

    assign w_dup = r_last_v && (w_corr == r_last);
    assign w_req = in_valid && !flush && !w_dup;

    always_ff @(posedge hash_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last   <= '0;
            r_last_v <= 1'b0;
        end else if (flush) begin
            r_last_v <= 1'b0;
        end else if (w_push) begin
            r_last   <= w_corr;
            r_last_v <= 1'b1;
        end
    end
`else
    assign w_req = in_valid && !flush;
`endif

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_push      = w_req && (!w_full || w_pop);
    assign w_drop      = w_req && w_full && !w_pop;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge hash_clk) begin
        if (w_push)
            r_mem[r_wptr] <= w_corr;
    end

    always_ff @(posedge hash_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_drop  <= '0;
            r_ovf   <= 1'b0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_wptr  <= w_push ? r_wptr + 1'b1 : r_wptr;
            r_rptr  <= w_pop ? r_rptr + 1'b1 : r_rptr;
            r_count <= w_count_nxt;
            r_drop  <= (w_drop && r_drop != 16'hFFFF) ? r_drop + 16'd1 : r_drop;
            r_ovf   <= r_ovf || w_drop;
        end
    end

    assign out_valid  = r_count != '0;
    assign out_nonce  = r_mem[r_rptr];
    assign count      = r_count;
    assign drop_count = r_drop;
    assign overflow   = r_ovf;
endmodule

// File: tb/tb_golden_nonce_queue.sv
// tb_golden_nonce_queue: directed self-checking bench for golden_nonce_queue (DEPTH=8, NONCE_OFFSET=130).
module tb_golden_nonce_queue;
    localparam int          DEPTH = 8;
    localparam logic [31:0] OFS   = 32'd130;

    logic        hash_clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_nonce;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_nonce;
    logic        out_ready;
    logic [3:0]  count;
    logic [15:0] drop_count;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    golden_nonce_queue #(.DEPTH(DEPTH), .NONCE_OFFSET(OFS)) dut (
        .hash_clk(hash_clk), .rst_n(rst_n), .in_valid(in_valid), .in_nonce(in_nonce),
        .flush(flush), .out_valid(out_valid), .out_nonce(out_nonce), .out_ready(out_ready),
        .count(count), .drop_count(drop_count), .overflow(overflow)
    );

    always #5 hash_clk = ~hash_clk;

    task automatic tick;
        @(posedge hash_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_nonce = '0; flush = 1'b0; out_ready = 1'b0;
        #12;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d expected 0", count); end
        total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL reset_drop: got %0d expected 0", drop_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        out_ready = 1'b1; in_valid = 1'b1; in_nonce = 32'd1000;
        tick;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        total++; if (out_nonce !== 32'd870) begin bad++; $display("FAIL single_nonce: got %0d expected 870", out_nonce); end
        total++; if (count !== 4'd1) begin bad++; $display("FAIL single_count1: got %0d expected 1", count); end
        tick;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL single_count0: got %0d expected 0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_valid0: got %b expected 0", out_valid); end
    endtask

    task automatic test_wrap;
        out_ready = 1'b0; in_valid = 1'b1; in_nonce = 32'd128;
        tick;
        in_valid = 1'b0;
        total++; if (out_nonce !== 32'hFFFFFFFE) begin bad++; $display("FAIL wrap_nonce: got %h expected fffffffe", out_nonce); end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL wrap_count: got %0d expected 0", count); end
    endtask

    task automatic test_fill_overflow;
        out_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1; in_nonce = OFS + 32'(i);
            tick;
        end
        in_valid = 1'b0;
        total++; if (count !== 4'd8) begin bad++; $display("FAIL fill_count: got %0d expected 8", count); end
        total++; if (drop_count !== 16'd2) begin bad++; $display("FAIL fill_drop: got %0d expected 2", drop_count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fill_ovf: got %b expected 1", overflow); end
        total++; if (out_nonce !== 32'd1) begin bad++; $display("FAIL fill_head: got %0d expected 1", out_nonce); end
        in_valid = 1'b1; in_nonce = OFS + 32'd99; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        total++; if (count !== 4'd8) begin bad++; $display("FAIL fullpp_count: got %0d expected 8", count); end
        total++; if (drop_count !== 16'd2) begin bad++; $display("FAIL fullpp_drop: got %0d expected 2", drop_count); end
        for (int i = 0; i < 8; i++) begin
            logic [31:0] exp;
            exp = (i < 7) ? 32'(i + 2) : 32'd99;
            total++; if (out_nonce !== exp || out_valid !== 1'b1) begin bad++; $display("FAIL drain_%0d: got %0d/%b expected %0d/1", i, out_nonce, out_valid, exp); end
            tick;
        end
        out_ready = 1'b0;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL drain_count: got %0d expected 0", count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_nonce = OFS + 32'(200 + i);
            tick;
            total++; if (out_nonce !== 32'(200 + i) || count !== 4'd1) begin bad++; $display("FAIL b2b_%0d: got %0d/%0d expected %0d/1", i, out_nonce, count, 200 + i); end
        end
        in_valid = 1'b0;
        tick;
        out_ready = 1'b0;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL b2b_end: got %0d expected 0", count); end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_nonce = OFS + 32'(10 + i);
            tick;
        end
        total++; if (count !== 4'd3) begin bad++; $display("FAIL flush_pre: got %0d expected 3", count); end
        in_valid = 1'b1; in_nonce = OFS + 32'd55; flush = 1'b1; out_ready = 1'b1;
        tick;
        in_valid = 1'b0; flush = 1'b0;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL flush_count: got %0d expected 0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL flush_ovf: got %b expected 0", overflow); end
        total++; if (drop_count !== 16'd2) begin bad++; $display("FAIL flush_drop: got %0d expected 2", drop_count); end
        tick;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no55: got %b expected 0", out_valid); end
    endtask

    task automatic test_mid_reset;
        out_ready = 1'b0;
        in_valid = 1'b1; in_nonce = OFS + 32'd1;
        tick;
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mrst_valid: got %b expected 0", out_valid); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL mrst_count: got %0d expected 0", count); end
        total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL mrst_drop: got %0d expected 0", drop_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mrst_ovf: got %b expected 0", overflow); end
        tick;
        rst_n = 1'b1;
        in_valid = 1'b1; in_nonce = OFS + 32'd77;
        tick;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_nonce !== 32'd77) begin bad++; $display("FAIL mrst_first: got %b/%0d expected 1/77", out_valid, out_nonce); end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

`ifdef GOLDEN_NONCE_DEDUP_EN
    task automatic test_dedup;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_nonce = OFS + ((i < 2) ? 32'd7 : 32'd8);
            tick;
        end
        in_valid = 1'b0;
        total++; if (count !== 4'd2) begin bad++; $display("FAIL dedup_count: got %0d expected 2", count); end
        total++; if (out_nonce !== 32'd7) begin bad++; $display("FAIL dedup_h0: got %0d expected 7", out_nonce); end
        out_ready = 1'b1;
        tick;
        total++; if (out_nonce !== 32'd8) begin bad++; $display("FAIL dedup_h1: got %0d expected 8", out_nonce); end
        tick;
        out_ready = 1'b0;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL dedup_end: got %0d expected 0", count); end
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_wrap;
        test_fill_overflow;
        test_back_to_back;
        test_flush;
        test_mid_reset;
`ifdef GOLDEN_NONCE_DEDUP_EN
        test_dedup;
`endif
        chk("final_count", 32'(count), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/golden_nonce_queue.md
# golden_nonce_queue

Buffers golden-nonce results from the hashing control unit and hands them to the communication block through a valid/ready handshake. Sits directly downstream of the miner top-level control logic, in the `hash_clk` domain. It subtracts the fixed pipeline offset from the raw nonce and queues results so none are lost while the host is slow to read. It also reports queue occupancy and lost results.

## Interface
Parameters:
- `DEPTH`, 8: queue entries; power of two, ≥2.
- `NONCE_OFFSET`, 32'd0: value subtracted (mod 2^32) from `in_nonce` before storage.

Ports:
- `hash_clk`  in  1  sole clock; all logic on rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `in_valid`  in  1  single-cycle golden-ticket strobe.
- `in_nonce`  in  32  raw nonce counter value sampled with `in_valid`.
- `flush`  in  1  new work arrived; discard all queued results.
- `out_valid`  out  1  head entry available.
- `out_nonce`  out  32  head entry; stable while `out_valid && !out_ready`.
- `out_ready`  in  1  consumer accepts head when high with `out_valid`.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `drop_count`  out  16  results lost to a full queue; saturates at 16'hFFFF.
- `overflow`  out  1  sticky; set on any drop.

## Operation
- Storage: circular buffer of `DEPTH`×32 registers, with write pointer, read pointer and occupancy counter.
- Push:
  - Condition: `in_valid && !flush && (count < DEPTH || pop)`.
  - Stored value: `in_nonce - NONCE_OFFSET`, 32-bit wrap (for example 0 − 2 = 32'hFFFFFFFE).
- Pop: `out_valid && out_ready`.
- Pointer wrap: pointers wrap modulo `DEPTH`. Occupancy is `count`, not pointer equality.
- Full queue:
  - Push without a same-cycle pop is dropped.
  - `drop_count` increments, saturating at 16'hFFFF.
  - `overflow` is set.
  - Queue contents are unchanged.
- Simultaneous push and pop: both occur.
  - `count` is unchanged.
  - Full case: the head leaves and the new entry is written to the freed slot. This is not a drop.
  - Empty case: the pop cannot happen (`out_valid` = 0), so only the push takes effect.
- Flush:
  - Pointers and `count` go to 0. `out_valid` deasserts the next cycle.
  - `overflow` is cleared. `drop_count` is retained.
  - Flush has priority over push and pop in the same cycle: both are ignored.
- Handshake rules:
  - `out_valid` never drops without a pop, flush or reset.
  - `out_nonce` is don't-care when `out_valid` = 0.
- Reset (`rst_n` = 0, any time, including mid-transfer): pointers, `count`, `drop_count`, `overflow` and `out_valid` go to 0 immediately. Storage contents are don't-care.

## Timing
- Push to visible: the push in cycle N appears on `out_valid`/`out_nonce` in cycle N+1 when the queue was empty.
- `count`, `drop_count` and `overflow` reflect cycle-N events at cycle N+1.
- Back-to-back: sustains one push and one pop per cycle with no bubbles.
- Outputs are registered or decoded from registered state only; no combinational path from `in_*` to `out_*`.
- `out_ready` to next head: 1 cycle.
- Reset release: synchronised externally. The first push is accepted on the first edge after deassertion.

## Configuration
- `GOLDEN_NONCE_DEDUP_EN` defined:
  - Holds a last-accepted register, plus a valid flag cleared by reset and flush.
  - A push whose corrected nonce equals the last accepted value is silently discarded: not stored, not counted, `overflow` unchanged.
  - Protects the host from repeated reports when the hasher stalls on a stop nonce.
- Undefined: no comparison logic. Every qualifying push is stored.

## Test plan
- Single result:
  - Stimulus: `NONCE_OFFSET`=130, `in_nonce`=1000 pulse, `out_ready`=1.
  - Response: `out_valid` high one cycle later with `out_nonce`=870, then `count` returns to 0.
- Underflow wrap:
  - Stimulus: `NONCE_OFFSET`=2, `in_nonce`=0.
  - Response: `out_nonce`=32'hFFFFFFFE.
- Fill and overflow:
  - Stimulus: `out_ready`=0, 10 pushes (nonces 1..10), `DEPTH`=8.
  - Response: `count`=8, `drop_count`=2, `overflow`=1. Draining yields 1..8 in order.
- Full push+pop:
  - Stimulus: full queue, push 99 with `out_ready`=1.
  - Response: `count` stays 8, `drop_count` unchanged, 99 emerges last.
- Flush priority:
  - Stimulus: 3 queued, then `flush` and `in_valid`(55) in the same cycle.
  - Response: `count`=0, `out_valid`=0 next cycle, `overflow`=0, 55 never emitted.
- Mid-operation reset:
  - Stimulus: `rst_n` low while `out_valid`=1.
  - Response: all outputs 0 immediately.
  - With `GOLDEN_NONCE_DEDUP_EN`: push 7 twice, then 8 → emits 7, 8 only.
